// File: rtl/rs_err_corrector.sv
// rs_err_corrector: buffers RS codewords and replays them with Chien/Forney error magnitudes XORed in.
module rs_err_corrector #(
  parameter int SYMB_WIDTH = 8,
  parameter int N_LEN = 255,
  parameter int T_LEN = 8,
  parameter int BUF_BLOCKS = 2
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic [SYMB_WIDTH-1:0] s_tdata,
  input  logic s_tvalid,
  output logic s_tready,
  input  logic s_tlast,
  input  logic err_vld,
  input  logic [T_LEN-1:0][SYMB_WIDTH-1:0] err_pos,
  input  logic [T_LEN-1:0] err_pos_vld,
  input  logic [T_LEN-1:0][SYMB_WIDTH-1:0] err_val,
  input  logic err_fail,
  output logic [SYMB_WIDTH-1:0] m_tdata,
  output logic m_tvalid,
  input  logic m_tready,
  output logic m_tlast,
  output logic m_tuser,
  output logic frame_err,
  output logic info_ovf
);
  localparam int DEPTH = BUF_BLOCKS * N_LEN;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(N_LEN);
  localparam int BW = $clog2(BUF_BLOCKS + 1);
  localparam int PW = BUF_BLOCKS > 1 ? $clog2(BUF_BLOCKS) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [SYMB_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [IW-1:0] in_idx, rd_idx, cur_idx;
  logic [BW-1:0] blk_avail, icnt, iavail;
  logic [PW-1:0] iw, il;
  logic [T_LEN-1:0][SYMB_WIDTH-1:0] f_pos [BUF_BLOCKS];
  logic [T_LEN-1:0][SYMB_WIDTH-1:0] f_val [BUF_BLOCKS];
  logic [T_LEN-1:0] f_msk [BUF_BLOCKS];
  logic f_fail [BUF_BLOCKS];
  logic [T_LEN-1:0][SYMB_WIDTH-1:0] wk_pos, wk_val, sel_pos, sel_val;
  logic [T_LEN-1:0] wk_msk, sel_msk;
  logic wk_fail, sel_fail;
  logic [SYMB_WIDTH-1:0] ram_q, s1_corr, corr, d;
  logic s1_v, s1_last, s1_fail;
  logic wr, in_wrap, done, push, out_ld, adv, go, run, issue, blk_end, latch;
  assign s_tready = cnt != CW'(DEPTH);
  assign wr = s_tvalid && s_tready;
  assign in_wrap = in_idx == IW'(N_LEN - 1);
  assign done = m_tvalid && m_tready && m_tlast;
  assign push = err_vld && (icnt != BW'(BUF_BLOCKS) || done);
  always_comb begin
    out_ld = !m_tvalid || m_tready;
    adv = !s1_v || out_ld;
    go = blk_avail != '0 && iavail != '0;
    run = state == RUN;
    issue = adv && (run || go);
    cur_idx = run ? rd_idx : '0;
    blk_end = issue && cur_idx == IW'(N_LEN - 1);
    latch = issue && (!run || (blk_end && go));
    state_nx = (issue && !run) ? RUN : (blk_end && !go) ? IDLE : state;
  end
  // The first symbol of a block is issued in the same cycle its info is latched, so it reads the FIFO head directly
  always_comb begin
    sel_pos = run ? wk_pos : f_pos[il];
    sel_val = run ? wk_val : f_val[il];
    sel_msk = run ? wk_msk : f_msk[il];
    sel_fail = run ? wk_fail : f_fail[il];
    d = SYMB_WIDTH'(N_LEN - 1) - SYMB_WIDTH'(cur_idx);
    corr = '0;
    for (int i = 0; i < T_LEN; i++)
      corr = corr ^ ((sel_msk[i] && sel_pos[i] == d) ? sel_val[i] : '0);
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      in_idx <= '0;
      rd_idx <= '0;
      cnt <= '0;
      blk_avail <= '0;
      icnt <= '0;
      iavail <= '0;
      iw <= '0;
      il <= '0;
      s1_v <= 1'b0;
      m_tvalid <= 1'b0;
      m_tdata <= '0;
      m_tlast <= 1'b0;
      m_tuser <= 1'b0;
      frame_err <= 1'b0;
      info_ovf <= 1'b0;
    end else begin
      frame_err <= wr && (s_tlast != in_wrap);
      info_ovf <= err_vld && !push;
      if (wr) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
        in_idx <= in_wrap ? '0 : in_idx + IW'(1);
      end
      if (issue) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
        rd_idx <= blk_end ? '0 : cur_idx + IW'(1);
      end
      if (push) iw <= (iw == PW'(BUF_BLOCKS - 1)) ? '0 : iw + PW'(1);
      if (latch) il <= (il == PW'(BUF_BLOCKS - 1)) ? '0 : il + PW'(1);
      cnt <= cnt + CW'(wr) - (done ? CW'(N_LEN) : '0);
      blk_avail <= blk_avail + BW'(wr && in_wrap) - BW'(latch);
      icnt <= icnt + BW'(push) - BW'(done);
      iavail <= iavail + BW'(push) - BW'(latch);
      if (adv) s1_v <= issue;
      if (out_ld) begin
        m_tvalid <= s1_v;
        if (s1_v) begin
          m_tdata <= ram_q ^ s1_corr;
          m_tlast <= s1_last;
          m_tuser <= s1_fail;
        end
      end
    end
  end
  always_ff @(posedge aclk) begin
    if (wr) mem[wr_ptr] <= s_tdata;
    if (push) begin
      f_pos[iw] <= err_pos;
      f_val[iw] <= err_val;
      f_msk[iw] <= err_pos_vld;
      f_fail[iw] <= err_fail;
    end
    if (latch) begin
      wk_pos <= f_pos[il];
      wk_val <= f_val[il];
      wk_msk <= f_msk[il];
      wk_fail <= f_fail[il];
    end
    if (issue) begin
      ram_q <= mem[rd_ptr];
      s1_corr <= sel_fail ? '0 : corr;
      s1_last <= blk_end;
      s1_fail <= sel_fail;
    end
  end
endmodule

// File: tb/tb_rs_err_corrector.sv
// tb_rs_err_corrector: directed stimulus against a block-level model of RS error correction.
module tb_rs_err_corrector;
  localparam int SW = 4, N = 15, T = 3, B = 2;
  localparam logic [N-1:0] TL = 15'h4000;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [SW-1:0] s_tdata = '0, m_tdata;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic err_vld = 1'b0, err_fail = 1'b0;
  logic [T-1:0][SW-1:0] err_pos = '0, err_val = '0;
  logic [T-1:0] err_pos_vld = '0;
  logic m_tvalid, m_tready = 1'b1, m_tlast, m_tuser, frame_err, info_ovf;
  always #5 aclk = ~aclk;
  rs_err_corrector #(.SYMB_WIDTH(SW), .N_LEN(N), .T_LEN(T), .BUF_BLOCKS(B)) dut (
    .aclk(aclk), .aresetn(aresetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .s_tlast(s_tlast), .err_vld(err_vld), .err_pos(err_pos), .err_pos_vld(err_pos_vld),
    .err_val(err_val), .err_fail(err_fail), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .m_tuser(m_tuser), .frame_err(frame_err), .info_ovf(info_ovf));
  typedef struct packed {logic [T-1:0][SW-1:0] pos; logic [T-1:0] msk; logic [T-1:0][SW-1:0] val; logic fail;} info_t;
  typedef struct packed {logic [SW-1:0] d; logic l; logic u;} out_t;
  logic [SW-1:0] sq[$];
  info_t iq[$];
  out_t eq[$], lg[$];
  int total = 0, bad = 0, occ = 0, iocc = 0, icount = 0, fe_seen = 0, ov_seen = 0, rmode = 0;
  logic fe_exp = 1'b0, ov_exp = 1'b0, pv = 1'b0, pr = 1'b0;
  out_t pout;
  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask
  // Model: blocks pair with accepted info in arrival order; output symbol k has degree N-1-k
  always @(negedge aclk) begin
    if (!aresetn) begin
      sq.delete(); iq.delete(); eq.delete();
      occ = 0; iocc = 0; icount = 0; fe_exp = 1'b0; ov_exp = 1'b0; pv = 1'b0;
    end else begin
      out_t o, e;
      info_t inf;
      logic [SW-1:0] dd, c;
      bit dn;
      o = {m_tdata, m_tlast, m_tuser};
      if (pv && !pr) begin
        chk("hold_valid", int'(m_tvalid), 1);
        chk("hold_payload", int'(o), int'(pout));
      end
      chk("s_tready", int'(s_tready), int'(occ < B * N));
      chk("frame_err", int'(frame_err), int'(fe_exp));
      chk("info_ovf", int'(info_ovf), int'(ov_exp));
      if (frame_err) fe_seen++;
      if (info_ovf) ov_seen++;
      dn = m_tvalid && m_tready && m_tlast;
      if (m_tvalid && m_tready) begin
        if (eq.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = eq.pop_front();
          chk("m_tdata", int'(m_tdata), int'(e.d));
          chk("m_tlast", int'(m_tlast), int'(e.l));
          chk("m_tuser", int'(m_tuser), int'(e.u));
          lg.push_back(o);
        end
      end
      pv = m_tvalid; pr = m_tready; pout = o;
      fe_exp = 1'b0; ov_exp = 1'b0;
      if (s_tvalid && s_tready) begin
        sq.push_back(s_tdata);
        fe_exp = s_tlast != (icount == N - 1);
        icount = (icount + 1) % N;
        occ++;
      end
      if (err_vld) begin
        if (iocc < B || dn) begin
          inf = {err_pos, err_pos_vld, err_val, err_fail};
          iq.push_back(inf);
          iocc++;
        end else ov_exp = 1'b1;
      end
      if (dn) begin occ -= N; iocc--; end
      while (sq.size() >= N && iq.size() > 0) begin
        inf = iq.pop_front();
        for (int k = 0; k < N; k++) begin
          dd = sq.pop_front();
          c = '0;
          for (int s = 0; s < T; s++)
            if (inf.msk[s] && int'(inf.pos[s]) == N - 1 - k) c = c ^ inf.val[s];
          e = {(inf.fail ? dd : dd ^ c), (k == N - 1), inf.fail};
          eq.push_back(e);
        end
      end
    end
  end
  initial forever begin
    @(posedge aclk); #1;
    m_tready = rmode == 0 ? 1'b1 : rmode == 2 ? 1'b0 : ($urandom_range(0, 1) == 1);
  end
  task automatic put_sym(input logic [SW-1:0] dv, input logic lv);
    int n = 0;
    bit ok;
    s_tdata = dv; s_tvalid = 1'b1; s_tlast = lv;
    while (1) begin
      @(negedge aclk); ok = s_tready;
      @(posedge aclk); #1;
      if (ok) break;
      if (++n > 3000) begin chk("tready_timeout", 1, 0); break; end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask
  task automatic send_block(input int base, input logic [N-1:0] tl);
    for (int k = 0; k < N; k++) put_sym(SW'(base + k), tl[k]);
  endtask
  task automatic info(input logic [T*SW-1:0] p, input logic [T-1:0] m, input logic [T*SW-1:0] v, input logic f);
    err_pos = p; err_pos_vld = m; err_val = v; err_fail = f; err_vld = 1'b1;
    @(posedge aclk); #1;
    err_vld = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while ((eq.size() != 0 || m_tvalid) && n < 3000) begin @(negedge aclk); n++; end
    if (n >= 3000) chk("drain_timeout", 1, 0);
    repeat (3) @(posedge aclk);
    #1;
  endtask
  initial begin
    int su, ov0, fe0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_m_tvalid", int'(m_tvalid), 0);
    chk("rst_s_tready", int'(s_tready), 1);
    chk("rst_m_tdata", int'(m_tdata), 0);
    chk("rst_pulses", int'({frame_err, info_ovf, m_tlast, m_tuser}), 0);
    aresetn = 1'b1;
    lg.delete();
    info('0, '0, '0, 1'b0);
    send_block(0, TL);
    @(posedge aclk); #1;
    chk("latency_1", int'(m_tvalid), 0);
    @(posedge aclk); #1;
    chk("latency_2", int'(m_tvalid), 1);
    drain();
    chk("t1_len", lg.size(), N);
    chk("t1_last", int'(lg[14].l), 1);
    chk("t1_notlast", int'(lg[13].l), 0);
    chk("t1_data5", int'(lg[5].d), 5);
    lg.delete();
    info({4'd0, 4'd3, 4'd14}, 3'b011, {4'd0, 4'd9, 4'd5}, 1'b0);
    send_block(0, TL);
    drain();
    chk("t2_idx0", int'(lg[0].d), 5);
    chk("t2_idx11", int'(lg[11].d), 2);
    chk("t2_idx3", int'(lg[3].d), 3);
    chk("t2_idx1", int'(lg[1].d), 1);
    lg.delete();
    info({4'd2, 4'd1, 4'd0}, 3'b111, {4'd1, 4'd1, 4'd1}, 1'b1);
    send_block(0, TL);
    drain();
    su = 0;
    foreach (lg[i]) su += int'(lg[i].u);
    chk("t3_tuser_cnt", su, 15);
    chk("t3_idx14", int'(lg[14].d), 14);
    lg.delete();
    info({4'd0, 4'd7, 4'd7}, 3'b011, {4'd0, 4'd6, 4'd3}, 1'b0);
    info({4'd0, 4'd0, 4'd15}, 3'b001, {4'd0, 4'd0, 4'd4}, 1'b0);
    send_block(0, TL);
    send_block(3, TL);
    drain();
    chk("t4_dup_idx7", int'(lg[7].d), 2);
    chk("t4_pos15_idx0", int'(lg[15].d), 3);
    chk("t4_pos15_idx14", int'(lg[29].d), 1);
    lg.delete();
    rmode = 2;
    ov0 = ov_seen;
    info('0, '0, '0, 1'b0);
    send_block(1, TL);
    send_block(2, TL);
    chk("t5_full_tready", int'(s_tready), 0);
    info({4'd0, 4'd0, 4'd14}, 3'b001, {4'd0, 4'd0, 4'd5}, 1'b0);
    info({4'd0, 4'd0, 4'd1}, 3'b001, {4'd0, 4'd0, 4'd15}, 1'b0);
    repeat (2) @(posedge aclk);
    #1;
    chk("t5_ovf_cnt", ov_seen - ov0, 1);
    rmode = 1;
    send_block(3, TL);
    info({4'd0, 4'd0, 4'd0}, 3'b001, {4'd0, 4'd0, 4'd8}, 1'b0);
    drain();
    rmode = 0;
    chk("t5_len", lg.size(), 3 * N);
    chk("t5_b0", int'(lg[0].d), 1);
    chk("t5_b1", int'(lg[15].d), 7);
    chk("t5_b2", int'(lg[44].d), 9);
    lg.delete();
    fe0 = fe_seen;
    info('0, '0, '0, 1'b0);
    send_block(4, 15'h4400);
    drain();
    chk("t6_frame_err_cnt", fe_seen - fe0, 1);
    info('0, '0, '0, 1'b0);
    send_block(5, TL);
    repeat (5) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    chk("t7_rst_m_tvalid", int'(m_tvalid), 0);
    chk("t7_rst_s_tready", int'(s_tready), 1);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    lg.delete();
    info({4'd0, 4'd0, 4'd14}, 3'b001, {4'd0, 4'd0, 4'd3}, 1'b0);
    send_block(6, TL);
    drain();
    chk("t7_len", lg.size(), N);
    chk("t7_first", int'(lg[0].d), 5);
    chk("t7_second", int'(lg[1].d), 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rs_err_corrector.md
Name: rs_err_corrector

Overview:
- Final stage of the RS decoder. Consumes the per-block error positions from the Chien search and the error magnitudes from the Forney stage.
- Buffers the received codeword stream until that block's error info arrives, then replays the block on an output stream, XOR-ing each magnitude into the symbol at the matching position.
- Blocks flagged as uncorrectable pass through unmodified, tagged via m_tuser.

Parameters:
- SYMB_WIDTH, 8, symbol width in bits (GF(2^m) element).
- N_LEN, 255, codeword length in symbols (may be shortened, N_LEN <= 2^SYMB_WIDTH-1).
- T_LEN, 8, maximum correctable errors per block; number of position/value slots.
- BUF_BLOCKS, 2, number of whole codewords the symbol buffer and the info FIFO can hold.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset, asynchronous, active-low
- s_tdata  in  SYMB_WIDTH  received symbol; first symbol of block = highest-degree coefficient
- s_tvalid  in  1  input symbol valid
- s_tready  out  1  buffer can accept a symbol
- s_tlast  in  1  last symbol of block (checked only)
- err_vld  in  1  one-cycle strobe: error info for oldest unmatched block
- err_pos  in  T_LEN x SYMB_WIDTH  error positions (polynomial degree)
- err_pos_vld  in  T_LEN  per-slot valid mask
- err_val  in  T_LEN x SYMB_WIDTH  error magnitudes, slot-aligned with err_pos
- err_fail  in  1  block uncorrectable (Chien error or count > T_LEN)
- m_tdata  out  SYMB_WIDTH  corrected symbol
- m_tvalid  out  1  output valid
- m_tready  in  1  downstream ready
- m_tlast  out  1  last symbol of block
- m_tuser  out  1  block uncorrectable, constant across the block
- frame_err  out  1  one-cycle pulse: s_tlast disagrees with internal block count
- info_ovf  out  1  one-cycle pulse: err_vld arrived with info FIFO full; info dropped

Behaviour:

Reset values:
- All outputs 0, except s_tready = 1 after reset.
- Write/read pointers, block counters and info FIFO cleared.
- Reset mid-block discards all buffered symbols and info. No partial block is ever emitted after reset.

Input side:
- Circular symbol RAM, depth BUF_BLOCKS*N_LEN.
- s_tready = 1 while free entries > 0.
- A symbol is written when s_tvalid && s_tready. in_idx increments and wraps N_LEN-1 -> 0.
- A block is complete when in_idx wraps.
- s_tlast is not used for framing. frame_err pulses the cycle after an accepted symbol where s_tlast != (in_idx == N_LEN-1).

Info FIFO:
- Depth BUF_BLOCKS; stores {err_pos, err_pos_vld, err_val, err_fail}.
- err_vld is never back-pressured. If it arrives when full, the entry is dropped and info_ovf pulses.
- Entries are matched to blocks in arrival order. Info may arrive before the block completes, while it is still being written.

Output FSM, states IDLE, RUN:
- IDLE -> RUN when at least one complete block is unsent and the info FIFO is non-empty. The head info entry is latched into a working register.
- In RUN, out_idx runs 0..N_LEN-1 and the current degree is d = N_LEN-1-out_idx.
- corr = XOR of err_val[i] over all i with err_pos_vld[i] && err_pos[i] == d. Duplicate positions therefore sum in GF.
- Positions >= N_LEN never match and are ignored.
- m_tdata = buf ^ corr when err_fail = 0, else buf unmodified.
- m_tuser = latched err_fail. m_tlast = (out_idx == N_LEN-1).
- RAM read is 1 cycle; m_tdata/m_tvalid are registered. Full throughput: one symbol per cycle while m_tready = 1.
- Latency: first m_tvalid is 2 cycles after the IDLE->RUN condition holds.
- AXI-stream rules: m_tdata/m_tlast/m_tuser are stable while m_tvalid && !m_tready, and m_tvalid does not drop without a handshake.

Boundaries:
- The last handshake of a block pops the info FIFO and frees N_LEN entries. If another block plus info is already ready, the FSM goes directly to the next block with no bubble.
- Write and read in the same cycle are allowed, including when the buffer is full: s_tready reflects the free count before the read.
- err_vld coinciding with a FIFO pop while full is accepted, with no overflow.

Test Plan (SYMB_WIDTH=4, N_LEN=15, T_LEN=3, BUF_BLOCKS=2):
- Block 0..14, info all err_pos_vld=0 -> output identical to input, m_tlast on symbol 14, m_tuser=0.
- Same block with err_pos={14,3,x}, err_val={5,9,x}, mask=3'b011 -> out_idx 0 data ^5, out_idx 11 data ^9, all other symbols unchanged.
- err_fail=1 with mask=3'b111 -> data passes unmodified, m_tuser=1 on all 15 symbols.
- Duplicate positions {7,7}, values {3,6} -> out_idx 7 XORed with 5; position 15 alone -> no change.
- Three blocks back-to-back, m_tready toggled 50%, info arriving early and late -> s_tready low once 30 symbols are buffered; ordering and correction per block preserved; third info with FIFO full -> info_ovf=1.
- s_tlast at symbol 10 -> frame_err pulse. aresetn low mid-output -> m_tvalid 0 immediately; the next block after reset is emitted correctly from its symbol 0.
